// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes,
// ALU/mux select encodings and the per-state control word.
// Latency: n/a (package). Backpressure: n/a.
package ctrl_pkg;

  // State encoding is also the STATE debug output value.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9,
    S_ALU_WB   = 4'd10,
    S_HALT     = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  // Opcodes (IR[15:12]); anything not listed is illegal.
  localparam logic [3:0] OPC_RTYPE = 4'd0;
  localparam logic [3:0] OPC_ADDI  = 4'd1;
  localparam logic [3:0] OPC_LW    = 4'd2;
  localparam logic [3:0] OPC_SW    = 4'd3;
  localparam logic [3:0] OPC_BEQ   = 4'd4;
  localparam logic [3:0] OPC_JAL   = 4'd5;
  localparam logic [3:0] OPC_HALT  = 4'd15;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_FUNC = 2'd2;  // R-type: ALU decodes funct field

  // ALU operand selects.
  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_REG = 1'b1;
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;   // PC increment (word addressed)
  localparam logic [1:0] SRCB_IMM = 2'd2;

  // Control word registered alongside the state. Input-qualified enables
  // (fetch/branch/mdr_cap) are combined with MEM_READY/ZERO at the outputs.
  typedef struct packed {
    logic       fetch;
    logic       mem_rd;
    logic       mem_wr;
    logic       mdr_cap;
    logic       aluout_wrt;
    logic       rf_wrt;
    logic       pc_wrt;
    logic       branch;
    logic       pc_src;
    logic       wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       err;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_rd    = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_ONE;
        c.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        c.aluout_wrt = 1'b1;
        c.alu_src_a  = SRCA_REG;
        c.alu_src_b  = SRCB_REG;
        c.alu_op     = ALUOP_FUNC;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.aluout_wrt = 1'b1;
        c.alu_src_a  = SRCA_REG;
        c.alu_src_b  = SRCB_IMM;
        c.alu_op     = ALUOP_ADD;
      end
      S_MEM_RD: begin
        c.mem_rd  = 1'b1;
        c.mdr_cap = 1'b1;
      end
      S_MEM_WB: begin
        c.rf_wrt = 1'b1;
        c.wb_sel = 1'b1;
      end
      S_MEM_WR: c.mem_wr = 1'b1;
      S_BRANCH: begin
        // Compare A-B for ZERO; PC_SRC=1 steers the target path into PC.
        c.branch    = 1'b1;
        c.pc_src    = 1'b1;
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_SUB;
      end
      S_JAL: begin
        c.pc_wrt    = 1'b1;
        c.pc_src    = 1'b1;
        c.rf_wrt    = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_ALU_WB: c.rf_wrt = 1'b1;
      S_HALT:   c.halted = 1'b1;
      S_ERROR:  c.err    = 1'b1;
      default:  c.err    = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Clearable memory-wait counter; flags the LIMIT-th cycle of a wait.
// Latency: expired is combinational from the count. Backpressure: none.
// Ports: clk, rst_n (async active-low), clr (restart count), expired.
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // cnt holds the number of wait cycles already elapsed, so expired is high
  // during the LIMIT-th cycle of the wait; the owner decides what wins then.
  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a 16-bit multicycle datapath with memory timeout.
// Latency: R/ADDI 4, LW 5, SW 4, BEQ 3, JAL 3 cycles at zero wait states.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until MEM_READY; ERROR on timeout.
// Ports: CLK, RST (async active-low), OPCODE/ZERO/MEM_READY in; register
// write enables, memory strobes, mux/ALU selects, HALTED/ERR, STATE out.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] OPCODE,
  input  logic            ZERO,
  input  logic            MEM_READY,
  output logic            PC_WRT,
  output logic            IR_WRT,
  output logic            MDR_WRT,
  output logic            ALUOUT_WRT,
  output logic            RF_WRT,
  output logic            MEM_RD,
  output logic            MEM_WR,
  output logic            ALU_SRC_A,
  output logic [1:0]      ALU_SRC_B,
  output logic [1:0]      ALU_OP,
  output logic            PC_SRC,
  output logic            WB_SEL,
  output logic            HALTED,
  output logic            ERR,
  output logic [3:0]      STATE
);

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   in_mem;
  logic   tmr_clr;
  logic   expired;

  assign in_mem = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // Holding the counter clear outside memory states and on the completing
  // cycle guarantees a zero count on entry to every memory state.
  assign tmr_clr = !in_mem || MEM_READY;

  wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (tmr_clr),
    .expired(expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: begin
        if (MEM_READY)    nxt = S_DECODE;   // ready wins over timeout
        else if (expired) nxt = S_ERROR;
      end
      S_DECODE: begin
        if      (OPCODE == OP_W'(OPC_RTYPE))                            nxt = S_EXEC_R;
        else if (OPCODE == OP_W'(OPC_ADDI))                             nxt = S_EXEC_I;
        else if (OPCODE == OP_W'(OPC_LW) || OPCODE == OP_W'(OPC_SW))    nxt = S_MEM_ADDR;
        else if (OPCODE == OP_W'(OPC_BEQ))                              nxt = S_BRANCH;
        else if (OPCODE == OP_W'(OPC_JAL))                              nxt = S_JAL;
        else if (OPCODE == OP_W'(OPC_HALT))                             nxt = S_HALT;
        else                                                            nxt = S_ERROR;
      end
      S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
      // IR is held through the instruction, so OPCODE still selects LW/SW.
      S_MEM_ADDR: nxt = (OPCODE == OP_W'(OPC_SW)) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (MEM_READY)    nxt = S_MEM_WB;
        else if (expired) nxt = S_ERROR;
      end
      S_MEM_WR: begin
        if (MEM_READY)    nxt = S_FETCH;
        else if (expired) nxt = S_ERROR;
      end
      S_MEM_WB, S_BRANCH, S_JAL, S_ALU_WB: nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_ERROR;
    endcase
  end

  // Control word is registered from the next state so it lines up with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_FETCH;
      ctrl  <= state_ctrl(S_FETCH);
    end else begin
      state <= nxt;
      ctrl  <= state_ctrl(nxt);
    end
  end

  // Enables and strobes are gated by RST so nothing fires while in reset,
  // and FETCH's read strobe appears as soon as reset is released.
  assign IR_WRT     = RST & ctrl.fetch & MEM_READY;
  assign PC_WRT     = RST & ((ctrl.fetch & MEM_READY) | (ctrl.branch & ZERO) | ctrl.pc_wrt);
  assign MDR_WRT    = RST & ctrl.mdr_cap & MEM_READY;
  assign ALUOUT_WRT = RST & ctrl.aluout_wrt;
  assign RF_WRT     = RST & ctrl.rf_wrt;
  assign MEM_RD     = RST & ctrl.mem_rd;
  assign MEM_WR     = RST & ctrl.mem_wr;

  assign ALU_SRC_A  = ctrl.alu_src_a;
  assign ALU_SRC_B  = ctrl.alu_src_b;
  assign ALU_OP     = ctrl.alu_op;
  assign PC_SRC     = ctrl.pc_src;
  assign WB_SEL     = ctrl.wb_sel;
  assign HALTED     = ctrl.halted;
  assign ERR        = ctrl.err;
  assign STATE      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of per-cycle vectors plus
// hand-written reset, wait-state, timeout, halt and illegal-opcode sequences.
// Latency/backpressure: n/a (testbench).
module tb_multicycle_control;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_EXEC_R = 4'd2,
                         ST_EXEC_I = 4'd3, ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5,
                         ST_MEM_WB = 4'd6, ST_MEM_WR = 4'd7,  ST_BRANCH = 4'd8,
                         ST_JAL = 4'd9,    ST_ALU_WB = 4'd10, ST_HALT = 4'd11,
                         ST_ERROR = 4'd12;

  // Observed bit order: {PC_WRT,IR_WRT,MDR_WRT,ALUOUT_WRT,RF_WRT,MEM_RD,MEM_WR,PC_SRC,WB_SEL,HALTED,ERR}
  localparam logic [10:0] B_PCW = 11'h400, B_IRW = 11'h200, B_MDR = 11'h100,
                          B_ALUO = 11'h080, B_RFW = 11'h040, B_MRD = 11'h020,
                          B_MWR = 11'h010, B_PCS = 11'h008, B_WBS = 11'h004,
                          B_HLT = 11'h002, B_ERR = 11'h001, B_NONE = 11'h000;
  localparam logic [10:0] FR = B_PCW | B_IRW | B_MRD;  // FETCH completing

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] OPCODE;
  logic       ZERO;
  logic       MEM_READY;
  logic       PC_WRT, IR_WRT, MDR_WRT, ALUOUT_WRT, RF_WRT, MEM_RD, MEM_WR;
  logic       ALU_SRC_A, PC_SRC, WB_SEL, HALTED, ERR;
  logic [1:0] ALU_SRC_B, ALU_OP;
  logic [3:0] STATE;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.OP_W(4), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .PC_WRT(PC_WRT), .IR_WRT(IR_WRT), .MDR_WRT(MDR_WRT), .ALUOUT_WRT(ALUOUT_WRT),
    .RF_WRT(RF_WRT), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .PC_SRC(PC_SRC), .WB_SEL(WB_SEL),
    .HALTED(HALTED), .ERR(ERR), .STATE(STATE)
  );

  typedef struct {
    logic [3:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] obs();
    return {PC_WRT, IR_WRT, MDR_WRT, ALUOUT_WRT, RF_WRT, MEM_RD, MEM_WR,
            PC_SRC, WB_SEL, HALTED, ERR};
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic [10:0] exp);
    tests++;
    if (STATE !== st || obs() !== exp) begin
      fails++;
      $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
               name, STATE, obs(), st, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; outputs are sampled 3 units in.
  task automatic cyc(input string name, input logic [3:0] op, input logic z,
                     input logic r, input logic [3:0] st, input logic [10:0] exp);
    OPCODE = op; ZERO = z; MEM_READY = r;
    #3;
    check(name, st, exp);
    @(posedge CLK); #1;
  endtask

  task automatic step(input logic [3:0] op, input logic z, input logic r);
    OPCODE = op; ZERO = z; MEM_READY = r;
    @(posedge CLK); #1;
  endtask

  task automatic add(input logic [3:0] op, input logic z, input logic r,
                     input logic [3:0] st, input logic [10:0] exp);
    vec_t v;
    v.op = op; v.zero = z; v.rdy = r; v.st = st; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    RST = 1'b0; MEM_READY = 1'b0; ZERO = 1'b0; OPCODE = 4'd0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mdr;

    // ---- vector table: one row per cycle, starting right after reset ----
    // R-type
    add(4'd0, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd0, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd0, 1'b0, 1'b1, ST_EXEC_R,   B_ALUO);
    add(4'd0, 1'b0, 1'b1, ST_ALU_WB,   B_RFW);
    // ADDI
    add(4'd1, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd1, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd1, 1'b0, 1'b1, ST_EXEC_I,   B_ALUO);
    add(4'd1, 1'b0, 1'b1, ST_ALU_WB,   B_RFW);
    // SW, zero wait
    add(4'd3, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd3, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd3, 1'b0, 1'b1, ST_MEM_ADDR, B_ALUO);
    add(4'd3, 1'b0, 1'b1, ST_MEM_WR,   B_MWR);
    // SW, one wait state
    add(4'd3, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd3, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd3, 1'b0, 1'b1, ST_MEM_ADDR, B_ALUO);
    add(4'd3, 1'b0, 1'b0, ST_MEM_WR,   B_MWR);
    add(4'd3, 1'b0, 1'b1, ST_MEM_WR,   B_MWR);
    // BEQ not taken, then taken
    add(4'd4, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd4, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd4, 1'b0, 1'b1, ST_BRANCH,   B_PCS);
    add(4'd4, 1'b1, 1'b1, ST_FETCH,    FR);
    add(4'd4, 1'b1, 1'b1, ST_DECODE,   B_NONE);
    add(4'd4, 1'b1, 1'b1, ST_BRANCH,   B_PCW | B_PCS);
    // JAL
    add(4'd5, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd5, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd5, 1'b0, 1'b1, ST_JAL,      B_PCW | B_PCS | B_RFW);
    // ADDI with two FETCH wait states
    add(4'd1, 1'b0, 1'b0, ST_FETCH,    B_MRD);
    add(4'd1, 1'b0, 1'b0, ST_FETCH,    B_MRD);
    add(4'd1, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd1, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd1, 1'b0, 1'b1, ST_EXEC_I,   B_ALUO);
    add(4'd1, 1'b0, 1'b1, ST_ALU_WB,   B_RFW);
    // LW, zero wait
    add(4'd2, 1'b0, 1'b1, ST_FETCH,    FR);
    add(4'd2, 1'b0, 1'b1, ST_DECODE,   B_NONE);
    add(4'd2, 1'b0, 1'b1, ST_MEM_ADDR, B_ALUO);
    add(4'd2, 1'b0, 1'b1, ST_MEM_RD,   B_MRD | B_MDR);
    add(4'd2, 1'b0, 1'b1, ST_MEM_WB,   B_RFW | B_WBS);

    // ---- reset: everything quiet even with MEM_READY/ZERO high ----
    RST = 1'b0; OPCODE = 4'd0; ZERO = 1'b1; MEM_READY = 1'b1;
    #12;
    check("reset_state", ST_FETCH, B_NONE);
    @(posedge CLK); #1;
    RST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("vec[%0d]", i), vecs[i].op, vecs[i].zero, vecs[i].rdy,
          vecs[i].st, vecs[i].exp);
    end

    // ---- LW with 3 wait states in MEM_RD: 8 cycles, one MDR pulse ----
    n = 0; mdr = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0 && STATE == ST_FETCH) break;
      OPCODE = 4'd2; ZERO = 1'b0;
      MEM_READY = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      #3;
      if (MDR_WRT) mdr++;
      @(posedge CLK); #1;
      n++;
    end
    check_val("lw_wait_cycles", n, 8);
    check_val("lw_mdr_pulses", mdr, 1);

    // ---- reset asserted mid MEM_RD wait ----
    step(4'd2, 1'b0, 1'b1);   // FETCH
    step(4'd2, 1'b0, 1'b1);   // DECODE
    step(4'd2, 1'b0, 1'b1);   // MEM_ADDR
    cyc("lw_waiting", 4'd2, 1'b0, 1'b0, ST_MEM_RD, B_MRD);
    #2;
    RST = 1'b0;
    #1;
    check("rst_async", ST_FETCH, B_NONE);
    @(posedge CLK); #1;
    check("rst_held", ST_FETCH, B_NONE);
    RST = 1'b1;
    cyc("rst_release_memrd", 4'd2, 1'b0, 1'b0, ST_FETCH, B_MRD);

    // ---- FETCH timeout: 15 wait cycles then ERROR ----
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) cyc("fetch_wait_15", 4'd0, 1'b0, 1'b0, ST_FETCH, B_MRD);
      else         step(4'd0, 1'b0, 1'b0);
    end
    cyc("timeout_err", 4'd0, 1'b0, 1'b1, ST_ERROR, B_ERR);
    cyc("timeout_err_stays", 4'd0, 1'b0, 1'b1, ST_ERROR, B_ERR);

    // ---- ready on the 15th wait cycle completes normally ----
    do_reset();
    for (int i = 1; i <= 14; i++) step(4'd0, 1'b0, 1'b0);
    cyc("ready_on_15", 4'd0, 1'b0, 1'b1, ST_FETCH, FR);
    cyc("ready_on_15_decode", 4'd0, 1'b0, 1'b1, ST_DECODE, B_NONE);
    cyc("ready_on_15_exec", 4'd0, 1'b0, 1'b1, ST_EXEC_R, B_ALUO);

    // ---- HALT is absorbing; reset clears it ----
    do_reset();
    step(4'd15, 1'b0, 1'b1);
    step(4'd15, 1'b0, 1'b1);
    cyc("halt_1", 4'd15, 1'b1, 1'b1, ST_HALT, B_HLT);
    cyc("halt_2", 4'd0,  1'b1, 1'b1, ST_HALT, B_HLT);
    cyc("halt_3", 4'd2,  1'b0, 1'b0, ST_HALT, B_HLT);
    RST = 1'b0;
    #1;
    check("halt_cleared", ST_FETCH, B_NONE);
    @(posedge CLK); #1;
    RST = 1'b1;

    // ---- illegal opcode 9 -> ERROR, absorbing; reset clears it ----
    step(4'd9, 1'b0, 1'b1);
    cyc("illegal_decode", 4'd9, 1'b0, 1'b1, ST_DECODE, B_NONE);
    cyc("illegal_err_1", 4'd9, 1'b0, 1'b1, ST_ERROR, B_ERR);
    cyc("illegal_err_2", 4'd0, 1'b1, 1'b1, ST_ERROR, B_ERR);
    RST = 1'b0;
    #1;
    check("err_cleared", ST_FETCH, B_NONE);
    @(posedge CLK); #1;
    RST = 1'b1;
    cyc("after_err_reset", 4'd0, 1'b0, 1'b1, ST_FETCH, FR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter OP_W, default 4: opcode width taken from IR[15:12].
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for MEM_READY before error.
REQ-003 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port OPCODE, input, OP_W bits: opcode field from the instruction register output.
REQ-006 The block SHALL have port ZERO, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have port MEM_READY, input, 1 bit: memory completes the current access this cycle.
REQ-008 The block SHALL have ports PC_WRT, IR_WRT, MDR_WRT, ALUOUT_WRT, RF_WRT, outputs, 1 bit each: WRT enables for the 16-bit Register instances and the register file.
REQ-009 The block SHALL have ports MEM_RD and MEM_WR, outputs, 1 bit each: memory request strobes.
REQ-010 The block SHALL have ports ALU_SRC_A (1 bit), ALU_SRC_B (2 bits), ALU_OP (2 bits), PC_SRC (1 bit) and WB_SEL (1 bit), all outputs: datapath mux and ALU selects.
REQ-011 The block SHALL have ports HALTED and ERR, outputs, 1 bit each: halt status and error status.
REQ-012 The block SHALL have port STATE, output, 4 bits: current state, for debug.

Function
REQ-013 The block SHALL implement a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, ALU_WB, HALT and ERROR.
REQ-014 Opcode decode SHALL be: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 JAL, 15 HALT; any other value SHALL be illegal.
REQ-015 FETCH: MEM_RD=1, and PC_WRT, IR_WRT SHALL be 1 only in a cycle where MEM_READY=1; the FSM SHALL stay in FETCH until MEM_READY=1, then go to DECODE.
REQ-016 DECODE SHALL last one cycle and go to: EXEC_R (op 0), EXEC_I (op 1), MEM_ADDR (ops 2/3), BRANCH (op 4), JAL (op 5), HALT (op 15), ERROR (illegal).
REQ-017 EXEC_R and EXEC_I SHALL assert ALUOUT_WRT and go to ALU_WB; ALU_WB SHALL assert RF_WRT with WB_SEL=0 and go to FETCH.
REQ-018 MEM_ADDR SHALL assert ALUOUT_WRT and go to MEM_RD (LW) or MEM_WR (SW).
REQ-019 MEM_RD/MEM_WR SHALL hold MEM_RD/MEM_WR high until MEM_READY=1; MDR_WRT SHALL equal MEM_READY in MEM_RD.
REQ-020 On MEM_READY=1, MEM_RD SHALL go to MEM_WB (RF_WRT=1, WB_SEL=1, then FETCH) and MEM_WR SHALL go to FETCH.
REQ-021 BRANCH SHALL assert PC_SRC=1 and PC_WRT=ZERO, then go to FETCH.
REQ-022 JAL SHALL assert PC_WRT=1, PC_SRC=1, RF_WRT=1, then go to FETCH.
REQ-023 HALT SHALL be absorbing with HALTED=1; ERROR SHALL be absorbing with ERR=1; both SHALL hold all enables at 0.
REQ-024 Latency (zero wait states) SHALL be: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, JAL 3.
REQ-025 The wait counter SHALL clear on entry to each memory state; if MEM_READY has not been seen after MEM_TIMEOUT cycles, the FSM SHALL go to ERROR.
REQ-026 MEM_READY=1 in the same cycle as the counter reaching MEM_TIMEOUT SHALL complete the access normally; ready wins.
REQ-027 All enables and strobes SHALL be 0 in every state not listed as asserting them.

Reset
REQ-028 RST=0 SHALL immediately force state FETCH, clear the counter, and clear HALTED and ERR, regardless of the current state, including mid-access.
REQ-029 While RST=0, all WRT enables and MEM_RD/MEM_WR SHALL be 0.
REQ-030 The first MEM_RD SHALL assert in the first cycle after RST is released.

Structure
REQ-031 Shared package ctrl_pkg SHALL hold the state encoding, opcode constants, and ALU_OP/ALU_SRC_B encodings.
REQ-032 One sub-module, wait_timer, SHALL implement the clearable MEM_TIMEOUT counter with a timeout flag.

Verification
REQ-033 The bench SHALL cover: RST=0 mid MEM_RD wait -> STATE=FETCH at once, all enables 0, MEM_RD=1 the cycle after release.
REQ-034 The bench SHALL cover: OPCODE=0, MEM_READY=1 -> states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; RF_WRT=1 only in cycle 4.
REQ-035 The bench SHALL cover: OPCODE=2 with MEM_READY low 3 cycles in MEM_RD -> LW completes in 8 cycles; MDR_WRT pulses exactly once.
REQ-036 The bench SHALL cover: OPCODE=4 with ZERO=0, then ZERO=1 -> PC_WRT=0, then PC_WRT=1 in the BRANCH cycle.
REQ-037 The bench SHALL cover: MEM_READY held 0 in FETCH -> ERR=1 after 15 wait cycles; MEM_READY=1 on cycle 15 instead -> normal DECODE.
REQ-038 The bench SHALL cover: OPCODE=15 -> HALTED=1 and stays 1; OPCODE=9 -> ERR=1 and stays 1; RST pulse clears both.
